// File: rtl/em_project_final_pd_pll_supervisor.sv
// Pixel PLL supervisor: drives the PLL reset, qualifies the synchronised
// lock signal and releases the video-domain reset once lock is stable.
module em_project_final_pd_pll_supervisor #(
    parameter int LOCK_SYNC_STAGES    = 2,
    parameter int PLL_RST_CYCLES      = 16,
    parameter int LOCK_STABLE_CYCLES  = 1000,
    parameter int LOCK_TIMEOUT_CYCLES = 50000,
    parameter int MAX_RETRIES         = 3
) (
    input  logic       refclk,
    input  logic       rst_n,
    input  logic       pll_locked,
    input  logic       soft_reset_req,
    output logic       pll_rst,
    output logic       sys_rst_n,
    output logic       ready,
    output logic       fail,
    output logic [3:0] retry_count,
    output logic [7:0] lock_loss_count
);

    localparam int MAX_AB = (PLL_RST_CYCLES > LOCK_STABLE_CYCLES) ?
                            PLL_RST_CYCLES : LOCK_STABLE_CYCLES;
    localparam int MAXP   = (MAX_AB > LOCK_TIMEOUT_CYCLES) ?
                            MAX_AB : LOCK_TIMEOUT_CYCLES;
    localparam int CW     = $clog2(MAXP + 1);

    localparam logic [CW-1:0] ONE      = CW'(1);
    localparam logic [CW-1:0] RST_LAST = CW'(PLL_RST_CYCLES - 1);
    localparam logic [CW-1:0] STB_LAST = CW'(LOCK_STABLE_CYCLES - 1);
    localparam logic [CW-1:0] TMO_LAST = CW'(LOCK_TIMEOUT_CYCLES - 1);
    localparam logic [3:0]    RTY_LAST = 4'(MAX_RETRIES - 1);

    typedef enum logic [2:0] {
        S_RESET_PLL,
        S_WAIT_LOCK,
        S_STABLE,
        S_RUN,
        S_FAIL
    } state_t;

    state_t                      state_q, state_d;
    logic [LOCK_SYNC_STAGES-1:0] sync_q;
    logic [CW-1:0]               cnt_q, cnt_d;
    logic [CW-1:0]               tmo_q, tmo_d;
    logic [3:0]                  retry_q, retry_d;
    logic [7:0]                  llc_q, llc_d;
    logic                        pll_rst_q, sys_rst_n_q, ready_q, fail_q;
    logic                        locked_s;
    logic                        tmo_hit;

    assign locked_s = sync_q[LOCK_SYNC_STAGES-1];

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        tmo_d   = tmo_q;
        retry_d = retry_q;
        llc_d   = llc_q;
        tmo_hit = 1'b0;
        unique case (state_q)
            S_RESET_PLL: begin
                cnt_d = cnt_q + ONE;
                if (cnt_q == RST_LAST) begin
                    state_d = S_WAIT_LOCK;
                    tmo_d   = '0;
                end
            end
            S_WAIT_LOCK: begin
                tmo_d = tmo_q + ONE;
                if (tmo_q == TMO_LAST) tmo_hit = 1'b1;
                else if (locked_s)     state_d = S_STABLE;
            end
            S_STABLE: begin
                // tmo keeps running so lock chatter cannot stall forever
                tmo_d = tmo_q + ONE;
                cnt_d = cnt_q + ONE;
                if (tmo_q == TMO_LAST) tmo_hit = 1'b1;
                else if (!locked_s)    state_d = S_WAIT_LOCK;
                else if (cnt_q == STB_LAST) begin
                    state_d = S_RUN;
                    retry_d = '0;
                end
            end
            S_RUN: begin
                if (!locked_s) begin
                    state_d = S_RESET_PLL;
                    if (llc_q != 8'hFF) llc_d = llc_q + 8'd1;
                end
            end
            S_FAIL: begin
                state_d = S_FAIL;
            end
            default: state_d = S_RESET_PLL;
        endcase
        if (tmo_hit) begin
            retry_d = retry_q + 4'd1;
            state_d = (retry_q == RTY_LAST) ? S_FAIL : S_RESET_PLL;
        end
        if (soft_reset_req) begin
            state_d = S_RESET_PLL;
            retry_d = '0;
            llc_d   = llc_q;
        end
        if ((state_d != state_q) || soft_reset_req) cnt_d = '0;
    end

    always_ff @(posedge refclk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_RESET_PLL;
            sync_q      <= '0;
            cnt_q       <= '0;
            tmo_q       <= '0;
            retry_q     <= '0;
            llc_q       <= '0;
            pll_rst_q   <= 1'b1;
            sys_rst_n_q <= 1'b0;
            ready_q     <= 1'b0;
            fail_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            sync_q      <= {sync_q[LOCK_SYNC_STAGES-2:0], pll_locked};
            cnt_q       <= cnt_d;
            tmo_q       <= tmo_d;
            retry_q     <= retry_d;
            llc_q       <= llc_d;
            pll_rst_q   <= (state_d == S_RESET_PLL);
            sys_rst_n_q <= (state_d == S_RUN);
            ready_q     <= (state_d == S_RUN);
            fail_q      <= (state_d == S_FAIL);
        end
    end

    assign pll_rst         = pll_rst_q;
    assign sys_rst_n       = sys_rst_n_q;
    assign ready           = ready_q;
    assign fail            = fail_q;
    assign retry_count     = retry_q;
    assign lock_loss_count = llc_q;

endmodule

// File: tb/tb_em_project_final_pd_pll_supervisor.sv
// Scoreboard bench for the PLL supervisor: expected output changes
// (value plus cycles since the previous change) are queued by stimulus.
module tb_em_project_final_pd_pll_supervisor;

    localparam int PRC = 4;
    localparam int LSC = 8;
    localparam int LTC = 32;
    localparam int MR  = 2;

    logic       refclk = 1'b0;
    logic       rst_n  = 1'b1;
    logic       pll_locked = 1'b0;
    logic       soft_reset_req = 1'b0;
    logic       pll_rst, sys_rst_n, ready, fail;
    logic [3:0] retry_count;
    logic [7:0] lock_loss_count;

    em_project_final_pd_pll_supervisor #(
        .LOCK_SYNC_STAGES    (2),
        .PLL_RST_CYCLES      (PRC),
        .LOCK_STABLE_CYCLES  (LSC),
        .LOCK_TIMEOUT_CYCLES (LTC),
        .MAX_RETRIES         (MR)
    ) dut (
        .refclk          (refclk),
        .rst_n           (rst_n),
        .pll_locked      (pll_locked),
        .soft_reset_req  (soft_reset_req),
        .pll_rst         (pll_rst),
        .sys_rst_n       (sys_rst_n),
        .ready           (ready),
        .fail            (fail),
        .retry_count     (retry_count),
        .lock_loss_count (lock_loss_count)
    );

    always #5 refclk = ~refclk;

    typedef struct packed {
        logic [15:0] v;
        int          dt;
        int          id;
    } exp_t;

    exp_t        q[$];
    int          compared = 0;
    int          mismatched = 0;
    int          ncyc = 0;
    int          sn = 0;
    int          eid = 1;
    bit          mon_en = 1'b0;
    logic [15:0] prev = '0;
    int          last = 0;

    wire [15:0] obs = {pll_rst, sys_rst_n, ready, fail,
                       retry_count, lock_loss_count};

    function automatic logic [15:0] mk(input bit pr, input bit sr,
                                       input bit rd, input bit fl,
                                       input logic [3:0] rc,
                                       input logic [7:0] lc);
        return {pr, sr, rd, fl, rc, lc};
    endfunction

    task automatic push(input logic [15:0] v, input int dt);
        exp_t e;
        e.v  = v;
        e.dt = dt;
        e.id = eid;
        eid++;
        q.push_back(e);
    endtask

    task automatic go(input int n);
        while (sn < n) begin
            @(negedge refclk);
            sn++;
        end
    endtask

    task automatic chk(input int id, input logic [15:0] exp);
        compared++;
        if (obs !== exp) begin
            mismatched++;
            $display("FAIL async_rst%0d: got %h required %h", id, obs, exp);
        end
    endtask

    // Monitor: every output change pops one expected entry
    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge refclk);
            ncyc++;
            if (!mon_en) begin
                prev = obs;
                last = ncyc;
            end else if (obs !== prev) begin
                compared++;
                if (q.size() == 0) begin
                    mismatched++;
                    $display("FAIL unexpected_change cyc=%0d got %h", ncyc, obs);
                end else begin
                    e = q.pop_front();
                    if (obs !== e.v || (ncyc - last) != e.dt) begin
                        mismatched++;
                        $display("FAIL evt%0d: got %h after %0d cycles, required %h after %0d cycles",
                                 e.id, obs, ncyc - last, e.v, e.dt);
                    end
                end
                prev = obs;
                last = ncyc;
            end
        end
    end

    initial begin : stim
        int          r;
        logic [7:0]  lc;
        #1 rst_n = 1'b0;
        #2 chk(0, mk(1, 0, 0, 0, 4'd0, 8'd0));

        // nominal lock
        go(3);
        push(mk(0, 0, 0, 0, 4'd0, 8'd0), 4);
        push(mk(0, 1, 1, 0, 4'd0, 8'd0), 21);
        #2 rst_n = 1'b1;
        mon_en = 1'b1;
        go(17); pll_locked = 1'b1;

        // lock loss in RUN, relock with chatter in STABLE
        push(mk(1, 0, 0, 0, 4'd0, 8'd1), 6);
        push(mk(0, 0, 0, 0, 4'd0, 8'd1), 4);
        push(mk(0, 1, 1, 0, 4'd0, 8'd1), 17);
        go(31); pll_locked = 1'b0;
        go(38); pll_locked = 1'b1;
        go(43); pll_locked = 1'b0;
        go(44); pll_locked = 1'b1;

        // timeout beats RUN after chatter, then timeout into FAIL
        push(mk(1, 0, 0, 0, 4'd0, 8'd2), 6);
        push(mk(0, 0, 0, 0, 4'd0, 8'd2), 4);
        push(mk(1, 0, 0, 0, 4'd1, 8'd2), 32);
        push(mk(0, 0, 0, 0, 4'd1, 8'd2), 4);
        push(mk(0, 0, 0, 1, 4'd2, 8'd2), 32);
        go(58); pll_locked = 1'b0;
        go(78); pll_locked = 1'b1;
        go(85); pll_locked = 1'b0;
        go(86); pll_locked = 1'b1;
        go(97); pll_locked = 1'b0;

        // recovery from FAIL
        push(mk(1, 0, 0, 0, 4'd0, 8'd2), 11);
        push(mk(0, 0, 0, 0, 4'd0, 8'd2), 4);
        push(mk(0, 1, 1, 0, 4'd0, 8'd2), 9);
        go(143); soft_reset_req = 1'b1;
        go(144); soft_reset_req = 1'b0;
        pll_locked = 1'b1;

        // async reset during RUN
        go(160); mon_en = 1'b0;
        #2 rst_n = 1'b0;
        #1 chk(1, mk(1, 0, 0, 0, 4'd0, 8'd0));
        go(163);
        push(mk(0, 0, 0, 0, 4'd0, 8'd0), 4);
        #2 rst_n = 1'b1;
        mon_en = 1'b1;

        // async reset during STABLE
        go(171); mon_en = 1'b0;
        #2 rst_n = 1'b0;
        #1 chk(2, mk(1, 0, 0, 0, 4'd0, 8'd0));
        go(174);
        push(mk(0, 0, 0, 0, 4'd0, 8'd0), 4);
        push(mk(0, 1, 1, 0, 4'd0, 8'd0), 9);
        #2 rst_n = 1'b1;
        mon_en = 1'b1;

        // 256 RUN lock losses; counter must hold at 255
        r = 187;
        for (int k = 1; k <= 256; k++) begin
            lc = (k > 255) ? 8'd255 : 8'(k);
            push(mk(1, 0, 0, 0, 4'd0, lc), 3);
            push(mk(0, 0, 0, 0, 4'd0, lc), 4);
            push(mk(0, 1, 1, 0, 4'd0, lc), 9);
            go(r);     pll_locked = 1'b0;
            go(r + 1); pll_locked = 1'b1;
            r = r + 16;
        end
        go(r + 5);

        compared++;
        if (q.size() != 0) begin
            mismatched++;
            $display("FAIL drain: got %0d pending events, required 0", q.size());
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 compared, mismatched);
        $finish;
    end

endmodule
